// File: rtl/execute_cycle_cc_pkg.sv
// Shared types for the execute stage: ALU op codes, branch funct3 codes and
// the ID/EX control bundle with its bubble value.
package execute_cycle_cc_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluOp_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } brFunct3_e;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       aluSrc;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
    logic [2:0] funct3;
  } exCtrl_t;

  typedef struct packed {
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pcPlus4;
    logic [REG_W-1:0] rd;
  } exData_t;

  // A bubble is an all-zero bundle: no writes, no branch/jump, not valid.
  localparam exCtrl_t EX_CTRL_BUBBLE = '0;

  // Direct register compare; 010/011 fall into default and never take.
  function automatic logic branchTaken(input logic [2:0] f3,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    case (f3)
      BR_EQ:   return a == b;
      BR_NE:   return a != b;
      BR_LT:   return $signed(a) <  $signed(b);
      BR_GE:   return $signed(a) >= $signed(b);
      BR_LTU:  return a <  b;
      BR_GEU:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_cycle_cc_if.sv
// Decode-to-execute bus, fetch redirect and EX/MEM results in one bundle.
// master drives the decode side; slave is the execute stage.
interface execute_cycle_cc_if;
  import execute_cycle_cc_pkg::*;

  logic             RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
  logic [1:0]       ResultSrcD;
  logic [2:0]       ALUControlD;
  logic [2:0]       Funct3D;
  logic [XLEN-1:0]  RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [REG_W-1:0] RdD;

  logic             PCSrcE;
  logic [XLEN-1:0]  PCTargetE;

  logic             RegWriteM, MemWriteM;
  logic [1:0]       ResultSrcM;
  logic [XLEN-1:0]  ALUResultM, WriteDataM, PCPlus4M;
  logic [REG_W-1:0] RdM;

  modport master (
    output RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD,
           ALUControlD, Funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, RdD,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RdM
  );

  modport slave (
    input  RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD,
           ALUControlD, Funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, RdD,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RdM
  );
endinterface

// File: rtl/execute_cycle_cc_alu.sv
// Combinational execute ALU with zero flag; unsupported op codes yield 0.
module alu_cc
  import execute_cycle_cc_pkg::*;
(
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [2:0]      aluControl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (aluControl)
      ALU_ADD: result = srcA + srcB;
      ALU_SUB: result = srcA - srcB;
      ALU_AND: result = srcA & srcB;
      ALU_OR:  result = srcA | srcB;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle_cc.sv
// Execute stage: ID/EX register, ALU/branch resolve, fetch redirect with
// two-bubble squash, EX/MEM register. BRANCH_EXT_EN enables full funct3 branches.
module execute_cycle_cc
  import execute_cycle_cc_pkg::*;
(
  input logic               clk,
  input logic               rst,
  execute_cycle_cc_if.slave bus
);

  exCtrl_t         ctrlE;
  exData_t         dataE;
  logic            squashE;
  logic [XLEN-1:0] srcBE, aluResultE;
  logic            zeroE, takenE, pcSrcE;

  assign srcBE = ctrlE.aluSrc ? dataE.imm : dataE.rd2;

  alu_cc uAlu (
    .srcA      (dataE.rd1),
    .srcB      (srcBE),
    .aluControl(ctrlE.aluControl),
    .result    (aluResultE),
    .zero      (zeroE)
  );

`ifdef BRANCH_EXT_EN
  assign takenE = branchTaken(ctrlE.funct3, dataE.rd1, dataE.rd2);
  logic unusedZero;
  assign unusedZero = zeroE;
`else
  // Every branch is beq, resolved by the ALU subtract.
  assign takenE = zeroE;
  logic unusedFunct3;
  assign unusedFunct3 = ^ctrlE.funct3;
`endif

  assign pcSrcE        = ctrlE.valid & (ctrlE.jump | (ctrlE.branch & takenE));
  assign bus.PCSrcE    = pcSrcE;
  assign bus.PCTargetE = dataE.pc + dataE.imm;

  // Redirect kills the D-stage instruction now; squashE kills the one
  // fetch issued during the redirect cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlE   <= EX_CTRL_BUBBLE;
      dataE   <= '0;
      squashE <= 1'b0;
    end else begin
      squashE <= pcSrcE;
      if (pcSrcE || squashE) begin
        ctrlE <= EX_CTRL_BUBBLE;
        dataE <= '0;
      end else begin
        ctrlE <= '{valid:      1'b1,
                   regWrite:   bus.RegWriteD,
                   memWrite:   bus.MemWriteD,
                   branch:     bus.BranchD,
                   jump:       bus.JumpD,
                   aluSrc:     bus.ALUSrcD,
                   resultSrc:  bus.ResultSrcD,
                   aluControl: bus.ALUControlD,
                   funct3:     bus.Funct3D};
        dataE <= '{rd1:     bus.RD1D,
                   rd2:     bus.RD2D,
                   imm:     bus.ImmExtD,
                   pc:      bus.PCD,
                   pcPlus4: bus.PCPlus4D,
                   rd:      bus.RdD};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.PCPlus4M   <= '0;
      bus.RdM        <= '0;
    end else begin
      bus.RegWriteM  <= ctrlE.regWrite;
      bus.MemWriteM  <= ctrlE.memWrite;
      bus.ResultSrcM <= ctrlE.resultSrc;
      bus.ALUResultM <= aluResultE;
      bus.WriteDataM <= dataE.rd2;
      bus.PCPlus4M   <= dataE.pcPlus4;
      bus.RdM        <= dataE.rd;
    end
  end

endmodule

// File: tb/tb_execute_cycle_cc.sv
// Bench for execute_cycle_cc: instruction-stream model plus literal checks.
module tb_execute_cycle_cc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_cycle_cc_if bus();
  execute_cycle_cc dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit        live, rw, mw, br, jp, src;
    bit [1:0]  rs;
    bit [2:0]  op, f3;
    bit [31:0] a, b, imm, pc, pc4;
    bit [4:0]  rd;
  } ins_t;

  ins_t q[$];
  int   nCmp = 0;
  int   nBad = 0;
  bit   ready = 0;

  function automatic ins_t nop();
    ins_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit [31:0] aluRef(input ins_t s);
    bit [31:0] y;
    y = s.src ? s.imm : s.b;
    case (s.op)
      3'd0: return s.a + y;
      3'd1: return s.a - y;
      3'd2: return s.a & y;
      3'd3: return s.a | y;
      3'd5: return ($signed(s.a) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit redirect(input ins_t s);
    bit tk;
`ifdef BRANCH_EXT_EN
    case (s.f3)
      3'd0: tk = (s.a == s.b);
      3'd1: tk = (s.a != s.b);
      3'd4: tk = ($signed(s.a) <  $signed(s.b));
      3'd5: tk = ($signed(s.a) >= $signed(s.b));
      3'd6: tk = (s.a <  s.b);
      3'd7: tk = (s.a >= s.b);
      default: tk = 0;
    endcase
`else
    tk = (aluRef(s) == 32'd0);
`endif
    return s.live && (s.jp || (s.br && tk));
  endfunction

  // An issued instruction dies if either of the two issued before it redirected.
  always @(posedge clk) begin
    bit   kill;
    ins_t n;
    if (rst) begin
      q.delete();
      ready = 1;
    end else begin
      kill = (q.size() >= 1 && redirect(q[q.size()-1])) ||
             (q.size() >= 2 && redirect(q[q.size()-2]));
      if (kill) n = nop();
      else begin
        n = nop();
        n.live = 1;           n.rw  = bus.RegWriteD;  n.mw  = bus.MemWriteD;
        n.br   = bus.BranchD; n.jp  = bus.JumpD;      n.src = bus.ALUSrcD;
        n.rs   = bus.ResultSrcD; n.op = bus.ALUControlD; n.f3 = bus.Funct3D;
        n.a    = bus.RD1D;    n.b   = bus.RD2D;       n.imm = bus.ImmExtD;
        n.pc   = bus.PCD;     n.pc4 = bus.PCPlus4D;   n.rd  = bus.RdD;
      end
      q.push_back(n);
      if (q.size() > 3) void'(q.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ins_t e, m;
    if (ready) begin
      e = (q.size() >= 1) ? q[q.size()-1] : nop();
      m = (q.size() >= 2) ? q[q.size()-2] : nop();
      chk("model PCSrcE",     32'(bus.PCSrcE),     32'(redirect(e)));
      chk("model PCTargetE",  bus.PCTargetE,       e.pc + e.imm);
      chk("model RegWriteM",  32'(bus.RegWriteM),  32'(m.rw));
      chk("model MemWriteM",  32'(bus.MemWriteM),  32'(m.mw));
      chk("model ResultSrcM", 32'(bus.ResultSrcM), 32'(m.rs));
      chk("model ALUResultM", bus.ALUResultM,      aluRef(m));
      chk("model WriteDataM", bus.WriteDataM,      m.b);
      chk("model PCPlus4M",   bus.PCPlus4M,        m.pc4);
      chk("model RdM",        32'(bus.RdM),        32'(m.rd));
    end
  end

  task automatic drive(input ins_t d);
    bus.RegWriteD = d.rw;  bus.MemWriteD = d.mw;  bus.BranchD = d.br;
    bus.JumpD = d.jp;      bus.ALUSrcD = d.src;   bus.ResultSrcD = d.rs;
    bus.ALUControlD = d.op; bus.Funct3D = d.f3;   bus.RD1D = d.a;
    bus.RD2D = d.b;        bus.ImmExtD = d.imm;   bus.PCD = d.pc;
    bus.PCPlus4D = d.pc4;  bus.RdD = d.rd;
  endtask

  task automatic step(input ins_t d);
    drive(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    ins_t d;
    bit [2:0] ops [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd7};
    drive(nop());
    rst = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset PCSrcE", 32'(bus.PCSrcE), 0);
    chk("reset PCTargetE", bus.PCTargetE, 0);
    chk("reset RegWriteM", 32'(bus.RegWriteM), 0);
    chk("reset MemWriteM", 32'(bus.MemWriteM), 0);
    chk("reset ALUResultM", bus.ALUResultM, 0);
    chk("reset RdM", 32'(bus.RdM), 0);
    rst = 0;

    d = nop(); d.a = 5; d.b = 7; d.rw = 1; d.rd = 3; d.pc4 = 32'h104; step(d);
    step(nop());
    chk("add ALUResultM", bus.ALUResultM, 12);
    chk("add RdM", 32'(bus.RdM), 3);
    chk("add RegWriteM", 32'(bus.RegWriteM), 1);
    chk("add PCPlus4M", bus.PCPlus4M, 32'h104);

    d = nop(); d.pc = 32'h10; d.imm = 32'h18; d.a = 9; d.b = 9; d.br = 1; d.op = 3'd1; step(d);
    chk("beq PCSrcE", 32'(bus.PCSrcE), 1);
    chk("beq PCTargetE", bus.PCTargetE, 32'h28);
    d = nop(); d.rw = 1; d.rd = 1; step(d);
    chk("squash-cycle PCSrcE", 32'(bus.PCSrcE), 0);
    d.rd = 2; step(d);
    chk("bubble1 RegWriteM", 32'(bus.RegWriteM), 0);
    d.rd = 3; step(d);
    chk("bubble2 RegWriteM", 32'(bus.RegWriteM), 0);
    step(nop());
    chk("post-branch RegWriteM", 32'(bus.RegWriteM), 1);
    chk("post-branch RdM", 32'(bus.RdM), 3);

    d = nop(); d.a = 1; d.b = 2; d.br = 1; d.op = 3'd1; step(d);
    chk("bne-path PCSrcE", 32'(bus.PCSrcE), 0);
    d = nop(); d.rw = 1; d.rd = 5; step(d);
    step(nop());
    chk("no-bubble RegWriteM", 32'(bus.RegWriteM), 1);
    chk("no-bubble RdM", 32'(bus.RdM), 5);

    foreach (ops[i]) begin
      d = nop(); d.op = ops[i]; d.a = 32'hFFFF_FFF0; d.b = 32'h0000_00FF;
      d.imm = 32'hFFFF_FFFD; d.src = i[0]; d.mw = ~i[0]; d.rs = i[1:0];
      d.rw = 1; d.rd = 5'(i + 10); d.pc4 = 32'h200 + 32'(i * 4);
      step(d);
    end
    d = nop(); d.op = 3'd5; d.a = 32'hFFFF_FFFF; d.b = 1; step(d);
    d = nop(); d.op = 3'd4; d.a = 32'h1234; d.b = 32'h1; step(d);
    chk("slt -1<1", bus.ALUResultM, 1);
    step(nop());
    chk("op100 gives 0", bus.ALUResultM, 0);

    d = nop(); d.jp = 1; d.pc = 32'h40; d.imm = 32'h100; step(d);
    chk("jump PCSrcE", 32'(bus.PCSrcE), 1);
    chk("jump PCTargetE", bus.PCTargetE, 32'h140);
    d = nop(); d.a = 4; d.b = 4; d.br = 1; d.op = 3'd1; d.pc = 32'h44; d.imm = 8; step(d);
    chk("killed beq1 PCSrcE", 32'(bus.PCSrcE), 0);
    step(d);
    chk("killed beq2 PCSrcE", 32'(bus.PCSrcE), 0);
    step(nop());

    d = nop(); d.jp = 1; d.rw = 1; d.rd = 1; d.pc = 32'h80; d.imm = 8; step(d);
    chk("jump2 PCSrcE", 32'(bus.PCSrcE), 1);
    rst = 1;
    d = nop(); d.rw = 1; d.rd = 9; step(d);
    chk("midreset PCSrcE", 32'(bus.PCSrcE), 0);
    chk("midreset PCTargetE", bus.PCTargetE, 0);
    chk("midreset RegWriteM", 32'(bus.RegWriteM), 0);
    chk("midreset RdM", 32'(bus.RdM), 0);
    rst = 0;
    d = nop(); d.rw = 1; d.rd = 7; step(d);
    step(nop());
    chk("after-reset RegWriteM", 32'(bus.RegWriteM), 1);
    chk("after-reset RdM", 32'(bus.RdM), 7);

`ifdef BRANCH_EXT_EN
    d = nop(); d.br = 1; d.a = 32'hFFFF_FFFF; d.b = 1; d.f3 = 3'd4; step(d);
    chk("blt signed PCSrcE", 32'(bus.PCSrcE), 1);
    step(nop()); step(nop());
    d.f3 = 3'd6; step(d);
    chk("bltu PCSrcE", 32'(bus.PCSrcE), 0);
    d.f3 = 3'd2; d.a = 3; d.b = 3; step(d);
    chk("f3 010 PCSrcE", 32'(bus.PCSrcE), 0);
`endif

    step(nop());
    step(nop());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
